// File: rtl/router_pkg.sv
// Shared constants for the router datapath: default byte width, address codes
// and header field positions.
package router_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ADDR_0       = 2'b00,
    ADDR_1       = 2'b01,
    ADDR_2       = 2'b10,
    ADDR_INVALID = 2'b11
  } addr_e;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;

  // The length field runs up to the top bit of the byte, so it scales with width.
  function automatic int len_msb(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/router_reg.sv
// Router datapath register: header capture, full-FIFO hold byte, XOR parity and error flag.
// Optional payload-length check enabled by defining ROUTER_REG_LEN_CHECK_EN.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err
);

  localparam int LEN_MSB = len_msb(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic                  pd_q, pd_d;
  logic                  lpv_q, lpv_d;
  logic                  err_q, err_d;
  logic                  mismatch;

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [LEN_MSB-LEN_LSB:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (detect_add)
      len_d = '0;
    else if (ld_state && pkt_valid && !(&len_q))
      len_d = len_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) len_q <= '0;
    else         len_q <= len_d;
  end

  assign mismatch = (int_par_q != pkt_par_q) || (len_q != header_q[LEN_MSB:LEN_LSB]);
`else
  assign mismatch = (int_par_q != pkt_par_q);
`endif

  always_comb begin
    header_d  = header_q;
    hold_d    = hold_q;
    dout_d    = dout_q;
    int_par_d = int_par_q;
    pkt_par_d = pkt_par_q;
    pd_d      = pd_q;
    lpv_d     = lpv_q;
    err_d     = err_q;

    if (detect_add && pkt_valid && (data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID))
      header_d = data_in;

    // full_state falls through to the hold branch: dout and hold_byte keep their values.
    if (lfd_state)                    dout_d = header_q;
    else if (ld_state && !fifo_full)  dout_d = data_in;
    else if (ld_state)                hold_d = data_in;
    else if (laf_state)               dout_d = hold_q;

    // Payload is counted on arrival, even if it is parked in hold_byte.
    if (detect_add)                   int_par_d = '0;
    else if (lfd_state)               int_par_d = int_par_q ^ header_q;
    else if (ld_state && pkt_valid)   int_par_d = int_par_q ^ data_in;

    if (ld_state && !pkt_valid) pkt_par_d = data_in;

    if (rst_int_reg)            lpv_d = 1'b0;
    if (ld_state && !pkt_valid) lpv_d = 1'b1;

    if (ld_state && !pkt_valid && !fifo_full) pd_d = 1'b1;
    if (laf_state && lpv_q && !pd_q)          pd_d = 1'b1;
    if (detect_add)                           pd_d = 1'b0;

    if (rst_int_reg && pd_q)       err_d = mismatch;
    if (detect_add && pkt_valid)   err_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_q  <= '0;
      hold_q    <= '0;
      dout_q    <= '0;
      int_par_q <= '0;
      pkt_par_q <= '0;
      pd_q      <= 1'b0;
      lpv_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      header_q  <= header_d;
      hold_q    <= hold_d;
      dout_q    <= dout_d;
      int_par_q <= int_par_d;
      pkt_par_q <= pkt_par_d;
      pd_q      <= pd_d;
      lpv_q     <= lpv_d;
      err_q     <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = pd_q;
  assign low_pkt_valid = lpv_q;
  assign err           = err_q;

`ifndef SYNTHESIS
  strobes_onehot: assert property (@(posedge clock) disable iff (!resetn)
    $onehot0({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}));
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: normal, bad parity, FIFO-full stalls, invalid address,
// async reset and payload-length check (result depends on ROUTER_REG_LEN_CHECK_EN).
module tb_router_reg;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RST  = 6'b000001;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full;
  logic [7:0] data_in;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  router_reg dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes/inputs, then settle 1 time unit past the edge.
  task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
    @(posedge clock);
    #1;
  endtask

  task automatic head(input logic [7:0] hdr);
    cyc(S_DA, 1'b1, hdr, 1'b0);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_pd", parity_done, 1'b0);
    check("rst_lpv", low_pkt_valid, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Normal packet
    head(8'h0D);
    check("norm_lfd_dout", dout, 8'h0D);
    cyc(S_LD, 1'b1, 8'h11, 1'b0); check("norm_dout11", dout, 8'h11);
    cyc(S_LD, 1'b1, 8'h22, 1'b0); check("norm_dout22", dout, 8'h22);
    cyc(S_LD, 1'b1, 8'h33, 1'b0); check("norm_dout33", dout, 8'h33);
    cyc(S_LD, 1'b0, 8'h0D, 1'b0);
    check("norm_dout_par", dout, 8'h0D);
    check("norm_pd", parity_done, 1'b1);
    check("norm_lpv", low_pkt_valid, 1'b1);
    check("norm_ipar", dut.int_par_q, 8'h0D);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    check("norm_err", err, 1'b0);
    check("norm_lpv_clr", low_pkt_valid, 1'b0);
    $display("txn normal packet done");

    // Bad parity
    head(8'h0D);
    cyc(S_LD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b0);
    cyc(S_LD, 1'b1, 8'h33, 1'b0);
    cyc(S_LD, 1'b0, 8'hFF, 1'b0);
    check("bad_err_pre", err, 1'b0);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    check("bad_err", err, 1'b1);
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    check("bad_err_hold", err, 1'b1);
    cyc(S_DA, 1'b1, 8'h0D, 1'b0);
    check("bad_err_clr", err, 1'b0);
    check("bad_pd_clr", parity_done, 1'b0);
    $display("txn bad parity done");

    // FIFO full mid-payload
    cyc(S_LFD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b1);
    check("full_dout_hold", dout, 8'h11);
    check("full_hold_byte", dut.hold_q, 8'h22);
    cyc(S_FULL, 1'b1, 8'h33, 1'b1);
    check("full_state_dout", dout, 8'h11);
    check("full_state_hold", dut.hold_q, 8'h22);
    cyc(S_LAF, 1'b1, 8'h33, 1'b0);
    check("full_laf_dout", dout, 8'h22);
    check("full_laf_pd", parity_done, 1'b0);
    cyc(S_LD, 1'b1, 8'h33, 1'b0); check("full_dout33", dout, 8'h33);
    cyc(S_LD, 1'b0, 8'h0D, 1'b0);
    check("full_ipar", dut.int_par_q, 8'h0D);
    check("full_pd", parity_done, 1'b1);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    check("full_err", err, 1'b0);
    $display("txn fifo full mid-payload done");

    // Parity byte arrives while full
    head(8'h0D);
    cyc(S_LD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b0);
    cyc(S_LD, 1'b1, 8'h33, 1'b0);
    cyc(S_LD, 1'b0, 8'h0D, 1'b1);
    check("pfull_lpv", low_pkt_valid, 1'b1);
    check("pfull_pd", parity_done, 1'b0);
    check("pfull_dout", dout, 8'h33);
    cyc(S_FULL, 1'b0, 8'h00, 1'b1);
    check("pfull_full_pd", parity_done, 1'b0);
    cyc(S_LAF, 1'b0, 8'h00, 1'b0);
    check("pfull_laf_dout", dout, 8'h0D);
    check("pfull_laf_pd", parity_done, 1'b1);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    check("pfull_err", err, 1'b0);
    check("pfull_lpv_clr", low_pkt_valid, 1'b0);
    $display("txn parity byte while full done");

    // Invalid address then async reset mid-payload
    cyc(S_DA, 1'b1, 8'h07, 1'b0);
    check("inv_header", dut.header_q, 8'h0D);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0);
    check("inv_lfd_dout", dout, 8'h0D);
    cyc(S_LD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b0, 8'h5A, 1'b1);
    check("pre_rst_lpv", low_pkt_valid, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_dout", dout, 8'h00);
    check("arst_lpv", low_pkt_valid, 1'b0);
    check("arst_pd", parity_done, 1'b0);
    check("arst_err", err, 1'b0);
    check("arst_header", dut.header_q, 8'h00);
    check("arst_hold", dut.hold_q, 8'h00);
    check("arst_ipar", dut.int_par_q, 8'h00);
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    $display("txn invalid address and async reset done");

    // Short packet: header length 3, only 2 payload bytes, correct XOR parity (0D^11^22=3E)
    head(8'h0D);
    cyc(S_LD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b1, 8'h22, 1'b0);
    cyc(S_LD, 1'b0, 8'h3E, 1'b0);
    check("short_pd", parity_done, 1'b1);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
`ifdef ROUTER_REG_LEN_CHECK_EN
    check("short_err_len", err, 1'b1);
`else
    check("short_err_par", err, 1'b0);
`endif
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    $display("txn short packet done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
